// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's request/response channel to the shared ALU
interface alu_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_val1;
  logic [31:0] req_val2;
  logic [3:0]  req_cmd;
  logic        req_s;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_nzcv;
  modport master (
    output req_valid, req_val1, req_val2, req_cmd, req_s, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_nzcv
  );
  modport slave (
    input  req_valid, req_val1, req_val2, req_cmd, req_s, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_nzcv
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters, owning NZCV status
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  r0,
  alu_arbiter_if.slave  r1,
  output logic [31:0]   alu_val1,
  output logic [31:0]   alu_val2,
  output logic [3:0]    alu_cmd,
  output logic          alu_c_in,
  input  logic [31:0]   alu_res,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_c_out,
  input  logic          alu_v,
  output logic [3:0]    status
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic        ptr, gnt, pick, any, idle, rsp_ok;
  logic [31:0] v1, v2, res;
  logic [3:0]  cmd, nzcv;
  logic        s;
  // grant selection and next-state; rst masks handshakes so a reset cycle never grants or responds
  always_comb begin
    any      = r0.req_valid | r1.req_valid;
    pick     = (r0.req_valid & r1.req_valid) ? ptr : r1.req_valid;
    idle     = state == IDLE && !rst;
    rsp_ok   = gnt ? r1.rsp_ready : r0.rsp_ready;
    state_nx = state == IDLE ? (any ? EXEC : IDLE) :
               state == EXEC ? RESP :
               (rsp_ok ? IDLE : RESP);
  end
  assign r0.req_ready = idle & any & ~pick;
  assign r1.req_ready = idle & any & pick;
  assign r0.rsp_valid = state == RESP && !rst && !gnt;
  assign r1.rsp_valid = state == RESP && !rst && gnt;
  assign r0.rsp_res   = res;
  assign r1.rsp_res   = res;
  assign r0.rsp_nzcv  = nzcv;
  assign r1.rsp_nzcv  = nzcv;
  assign alu_val1     = v1;
  assign alu_val2     = v2;
  assign alu_cmd      = cmd;
  assign alu_c_in     = status[1];
  // operand capture on grant, result/status capture in EXEC, pointer flip on response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= RR_INIT;
      status <= 4'b0000;
      v1     <= '0;
      v2     <= '0;
      cmd    <= '0;
      s      <= 1'b0;
      gnt    <= 1'b0;
      res    <= '0;
      nzcv   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        v1  <= pick ? r1.req_val1 : r0.req_val1;
        v2  <= pick ? r1.req_val2 : r0.req_val2;
        cmd <= pick ? r1.req_cmd  : r0.req_cmd;
        s   <= pick ? r1.req_s    : r0.req_s;
        gnt <= pick;
      end
      if (state == EXEC) begin
        res  <= alu_res;
        nzcv <= {alu_n, alu_z, alu_c_out, alu_v};
        if (s) status <= {alu_n, alu_z, alu_c_out, alu_v};
      end
      if (state == RESP && rsp_ok) ptr <= ~gnt;
    end
  end
endmodule
